// File: rtl/multi_channel_accumulator.sv
// NUM_CH independent wrap/saturate accumulators with sticky overflow flags and a
// single-entry valid/ready snapshot port that can atomically clear the channel it reads.

module multi_channel_accumulator_ch #(
    parameter int ACC_WIDTH = 16,
    parameter int ADD_WIDTH = 8,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sat_en,
    input  logic                 add_en,
    input  logic                 clr_en,
    input  logic [ADD_WIDTH-1:0] value,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 ovf
);
    logic [ACC_WIDTH-1:0] ext, lim, nxt;
    logic [ACC_WIDTH:0]   sum;
    logic                 oor;

    always_comb begin
        ext = '0;
        ext[ADD_WIDTH-1:0] = value;
        if (SIGNED != 0)
            for (int i = ADD_WIDTH; i < ACC_WIDTH; i++) ext[i] = value[ADD_WIDTH-1];
    end

    assign sum = {1'b0, acc} + {1'b0, ext};

    // Signed overflow only when both operands share a sign the result lost.
    always_comb begin
        if (SIGNED != 0)
            oor = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        else
            oor = sum[ACC_WIDTH];
    end

    always_comb begin
        lim = '1;
        if (SIGNED != 0) begin
            lim = '0;
            lim[ACC_WIDTH-1] = 1'b1;
            if (!acc[ACC_WIDTH-1]) lim = ~lim;
        end
        nxt = (oor && sat_en) ? lim : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clr_en) begin
            acc <= add_en ? ext : '0;
            ovf <= 1'b0;
        end else if (add_en) begin
            acc <= nxt;
            ovf <= ovf | oor;
        end
    end
endmodule

module multi_channel_accumulator #(
    parameter int  NUM_CH    = 4,
    parameter int  ACC_WIDTH = 16,
    parameter int  ADD_WIDTH = 8,
    parameter int  SIGNED    = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sat_en,
    input  logic                 in_valid,
    input  logic [CH_W-1:0]      in_ch,
    input  logic [ADD_WIDTH-1:0] in_value,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [CH_W-1:0]      rd_ch,
    input  logic                 rd_clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH_W-1:0]      out_ch,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);
    logic [NUM_CH-1:0][ACC_WIDTH-1:0] acc_q;
    logic [NUM_CH-1:0]                ovf_q;
    logic                             rd_fire, rd_hit;

    assign rd_ready = !out_valid || out_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_hit   = int'(rd_ch) < NUM_CH;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_channel_accumulator_ch #(
            .ACC_WIDTH(ACC_WIDTH), .ADD_WIDTH(ADD_WIDTH), .SIGNED(SIGNED)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .sat_en(sat_en),
            .add_en(in_valid && (in_ch == CH_W'(i))),
            .clr_en(rd_fire && rd_clear && (rd_ch == CH_W'(i))),
            .value (in_value),
            .acc   (acc_q[i]),
            .ovf   (ovf_q[i])
        );
    end

    // Snapshot reads the registered state, i.e. before this cycle's add lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (rd_fire) begin
            out_valid <= 1'b1;
            out_ch    <= rd_ch;
            out_data  <= rd_hit ? acc_q[rd_ch] : '0;
            out_ovf   <= rd_hit ? ovf_q[rd_ch] : 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
